// File: rtl/btn_conditioner.sv
// Push-button front-end for the lock core: synchronise, debounce, then edge-detect btn_0/btn_1.
// Simultaneous presses are rejected through a two-state lockout and reported on err_both.
module btn_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic btn_reset,
  input  logic btn_0,
  input  logic btn_1,
  output logic db_0,
  output logic db_1,
  output logic pulse_0,
  output logic pulse_1,
  output logic err_both,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // One debounce step: returns {next db, next count}. A sample that agrees
  // with the committed level clears the count, so a glitch restarts it.
  function automatic logic [CNT_W:0] db_step(
    input logic             s,
    input logic             db,
    input logic [CNT_W-1:0] cnt
  );
    logic [CNT_W:0] r;
    r = {db, CNT_ZERO};
    if (s != db) begin
      if (cnt == CNT_LAST) r = {s, CNT_ZERO};
      else                 r = {db, cnt + 1'b1};
    end
    return r;
  endfunction

  logic [SYNC_STAGES-1:0] sync_0;
  logic [SYNC_STAGES-1:0] sync_1;
  logic                   s_0;
  logic                   s_1;

  logic [CNT_W-1:0]       cnt_0;
  logic [CNT_W-1:0]       cnt_1;
  logic [CNT_W-1:0]       nxt_cnt_0;
  logic [CNT_W-1:0]       nxt_cnt_1;
  logic                   nxt_db_0;
  logic                   nxt_db_1;
  logic                   rise_0;
  logic                   rise_1;

  logic [0:0]             state;
  logic [0:0]             nxt_state;
  logic                   nxt_pulse_0;
  logic                   nxt_pulse_1;
  logic                   nxt_err;
  logic                   nxt_busy;

  // Input synchronisers (buttons are asynchronous to clk)
  always_ff @(posedge clk or posedge btn_reset) begin
    if (btn_reset) begin
      sync_0 <= '0;
      sync_1 <= '0;
    end else begin
      sync_0 <= {sync_0[SYNC_STAGES-2:0], btn_0};
      sync_1 <= {sync_1[SYNC_STAGES-2:0], btn_1};
    end
  end

  assign s_0 = sync_0[SYNC_STAGES-1];
  assign s_1 = sync_1[SYNC_STAGES-1];

  // Debounce, lockout and strobe decisions, all made on next-state values
  always_comb begin
    {nxt_db_0, nxt_cnt_0} = db_step(s_0, db_0, cnt_0);
    {nxt_db_1, nxt_cnt_1} = db_step(s_1, db_1, cnt_1);

    rise_0 = nxt_db_0 & ~db_0;
    rise_1 = nxt_db_1 & ~db_1;

    nxt_state = state;
    nxt_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (nxt_db_0 && nxt_db_1) begin
          nxt_state = ST_LOCKED;
          nxt_err   = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (!nxt_db_0 && !nxt_db_1) nxt_state = ST_IDLE;
      end
      default: nxt_state = ST_IDLE;
    endcase

    // A press only counts if the other button is fully released and stays so
    nxt_pulse_0 = rise_0 & ~db_1 & ~nxt_db_1 & (state == ST_IDLE);
    nxt_pulse_1 = rise_1 & ~db_0 & ~nxt_db_0 & (state == ST_IDLE);

    nxt_busy = (nxt_cnt_0 != CNT_ZERO) | (nxt_cnt_1 != CNT_ZERO);
  end

  // Registered outputs, counters and lockout state
  always_ff @(posedge clk or posedge btn_reset) begin
    if (btn_reset) begin
      cnt_0    <= '0;
      cnt_1    <= '0;
      db_0     <= 1'b0;
      db_1     <= 1'b0;
      pulse_0  <= 1'b0;
      pulse_1  <= 1'b0;
      err_both <= 1'b0;
      busy     <= 1'b0;
      state    <= ST_IDLE;
    end else begin
      cnt_0    <= nxt_cnt_0;
      cnt_1    <= nxt_cnt_1;
      db_0     <= nxt_db_0;
      db_1     <= nxt_db_1;
      pulse_0  <= nxt_pulse_0;
      pulse_1  <= nxt_pulse_1;
      err_both <= nxt_err;
      busy     <= nxt_busy;
      state    <= nxt_state;
    end
  end

endmodule
